// File: rtl/lf_trigger_pkg.sv
// Shared constants, run-state encoding and output word packing for the LF trigger generator.
package lf_trigger_pkg;

  localparam int TS_BITS  = 24;
  localparam int BEAM_LSB = 24;
  localparam int TS_MSB   = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [31:0] pack_trig_word(input logic [7:0] beam,
                                                 input logic [TS_BITS-1:0] ts);
    logic [31:0] w;
    w = '0;
    w[31:BEAM_LSB] = beam;
    w[TS_MSB:0]    = ts;
    return w;
  endfunction

endpackage

// File: rtl/lf_trig_fifo.sv
// First-word-fall-through FIFO with synchronous flush; rd_data_o shows the head word while !empty_o.
module lf_trig_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lf_trigger_generator.sv
// Run-controlled LF trigger back end: mask, per-beam holdoff, timestamp, serialise into an AXI4-S FIFO.
// Drop detection and counter are built only when LF_TRIG_DROPCOUNT_EN is defined.
module lf_trigger_generator
  import lf_trigger_pkg::*;
#(
  parameter int NBEAMS       = 48,
  parameter int HOLDOFF_BITS = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    ifclk,
  input  logic                    ifclk_rstn_i,
  input  logic                    runrst_i,
  input  logic                    runstop_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       beam_mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic [31:0]             m_trig_tdata,
  output logic                    m_trig_tvalid,
  input  logic                    m_trig_tready,
  output logic                    running_o,
  output logic [15:0]             drop_count_o
);

  state_e             state_q, state_d;
  logic [TS_BITS-1:0] ts_q, ts_d;
  logic [NBEAMS-1:0]  pending_q, pending_d;
  logic [NBEAMS-1:0]  fire, hold_zero, first_oh;
  logic [31:0]        sel_word [NBEAMS];
  logic [31:0]        scan_word, fifo_rdata;
  logic               flush, in_run, scan_en, fifo_full, fifo_empty;

  assign flush  = runrst_i;
  assign in_run = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    if (runrst_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (runstop_i) state_d = DRAIN;
        DRAIN:   if ((pending_q == '0) && fifo_empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ts_d = ts_q;
    if (flush)                ts_d = '0;
    else if (state_q != IDLE) ts_d = ts_q + TS_BITS'(1);
  end

  // Lowest set pending bit, isolated as a one-hot mask.
  assign first_oh = pending_q & (~pending_q + NBEAMS'(1));
  assign scan_en  = (|pending_q) & ~fifo_full & ~flush;

  always_comb begin
    pending_d = (pending_q | fire) & ~(scan_en ? first_oh : '0);
    if (flush) pending_d = '0;
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    logic [HOLDOFF_BITS-1:0] hold_q;
    logic [TS_BITS-1:0]      stamp_q;

    always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
      if (!ifclk_rstn_i) begin
        hold_q  <= '0;
        stamp_q <= '0;
      end else if (flush) begin
        hold_q  <= '0;
        stamp_q <= '0;
      end else if (fire[b]) begin
        hold_q  <= holdoff_i;
        stamp_q <= ts_q;
      end else if (hold_q != '0) begin
        hold_q  <= hold_q - HOLDOFF_BITS'(1);
      end
    end

    assign hold_zero[b] = (hold_q == '0);
    assign fire[b]      = in_run & trig_i[b] & beam_mask_i[b] & hold_zero[b] & ~pending_q[b];
    assign sel_word[b]  = first_oh[b] ? pack_trig_word(8'(b), stamp_q) : '0;
  end

  always_comb begin
    scan_word = '0;
    for (int b = 0; b < NBEAMS; b++) scan_word = scan_word | sel_word[b];
  end

  always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
    if (!ifclk_rstn_i) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      pending_q <= pending_d;
    end
  end

  lf_trig_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (ifclk),
    .rst_ni    (ifclk_rstn_i),
    .flush_i   (flush),
    .wr_en_i   (scan_en),
    .wr_data_i (scan_word),
    .rd_en_i   (m_trig_tready),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Gate the head word so tdata reads zero whenever nothing is offered.
  assign m_trig_tvalid = ~fifo_empty;
  assign m_trig_tdata  = fifo_empty ? '0 : fifo_rdata;
  assign running_o     = in_run;

`ifdef LF_TRIG_DROPCOUNT_EN
  logic [15:0] drop_q, drop_d;
  logic        drop_any;

  assign drop_any = in_run & (|(trig_i & beam_mask_i & hold_zero & pending_q));

  always_comb begin
    drop_d = drop_q;
    if (flush)                                  drop_d = '0;
    else if (drop_any && (drop_q != 16'hFFFF))  drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
    if (!ifclk_rstn_i) drop_q <= '0;
    else               drop_q <= drop_d;
  end

  assign drop_count_o = drop_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_lf_trigger_generator.sv
// Self-checking bench for lf_trigger_generator: vector table plus hand-written run-control sequences.
module tb_lf_trigger_generator;

  localparam int NB = 48;

  logic          ifclk = 1'b0;
  logic          ifclk_rstn_i;
  logic          runrst_i;
  logic          runstop_i;
  logic [NB-1:0] trig_i;
  logic [NB-1:0] beam_mask_i;
  logic [15:0]   holdoff_i;
  logic [31:0]   m_trig_tdata;
  logic          m_trig_tvalid;
  logic          m_trig_tready;
  logic          running_o;
  logic [15:0]   drop_count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_base = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [NB-1:0] trig;
    logic [NB-1:0] mask;
    int            nwords;
  } vec_t;
  vec_t vecs [5];

  lf_trigger_generator #(
    .NBEAMS       (NB),
    .HOLDOFF_BITS (16),
    .FIFO_DEPTH   (16)
  ) dut (
    .ifclk         (ifclk),
    .ifclk_rstn_i  (ifclk_rstn_i),
    .runrst_i      (runrst_i),
    .runstop_i     (runstop_i),
    .trig_i        (trig_i),
    .beam_mask_i   (beam_mask_i),
    .holdoff_i     (holdoff_i),
    .m_trig_tdata  (m_trig_tdata),
    .m_trig_tvalid (m_trig_tvalid),
    .m_trig_tready (m_trig_tready),
    .running_o     (running_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 ifclk = ~ifclk;
  always @(posedge ifclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected word.
  always @(negedge ifclk) begin
    logic [31:0] w;
    if (ifclk_rstn_i && m_trig_tvalid && m_trig_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h expected=none", m_trig_tdata);
      end else begin
        w = exp_q.pop_front();
        check("stream_word", m_trig_tdata, w);
      end
    end
  end

  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [23:0] cur_ts();
    return 24'(cyc - run_base);
  endfunction

  function automatic logic [NB-1:0] beams(input int lo, input int hi);
    logic [NB-1:0] v;
    v = '0;
    for (int b = lo; b <= hi; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic do_runrst();
    runrst_i = 1'b1;
    step();
    runrst_i = 1'b0;
    run_base = cyc;
  endtask

  task automatic fire(input logic [NB-1:0] drive, input logic [NB-1:0] expect_set);
    logic [23:0] ts;
    ts = cur_ts();
    for (int b = 0; b < NB; b++)
      if (expect_set[b]) exp_q.push_back({8'(b), ts});
    trig_i = drive;
    step();
    trig_i = '0;
  endtask

  initial begin
    logic [31:0] head;
    logic [15:0] exp_drop4, exp_drop5;
`ifdef LF_TRIG_DROPCOUNT_EN
    exp_drop4 = 16'd4;
    exp_drop5 = 16'd5;
`else
    exp_drop4 = 16'd0;
    exp_drop5 = 16'd0;
`endif

    vecs[0] = '{48'h0000_0000_0020, {NB{1'b1}}, 1};
    vecs[1] = '{48'h8000_0000_0081, {NB{1'b1}}, 3};
    vecs[2] = '{48'h0000_0000_000E, ~48'h0000_0000_0004, 2};
    vecs[3] = '{48'h0000_0000_00FF, 48'h0000_0000_000F, 4};
    vecs[4] = '{{NB{1'b1}}, '0, 0};

    ifclk_rstn_i  = 1'b0;
    runrst_i      = 1'b0;
    runstop_i     = 1'b0;
    trig_i        = '0;
    beam_mask_i   = {NB{1'b1}};
    holdoff_i     = 16'd0;
    m_trig_tready = 1'b1;
    step_n(3);
    check("rst_tvalid", 32'(m_trig_tvalid), 0);
    check("rst_tdata", m_trig_tdata, 0);
    check("rst_running", 32'(running_o), 0);
    check("rst_drop", 32'(drop_count_o), 0);
    ifclk_rstn_i = 1'b1;
    step();

    // IDLE ignores triggers.
    trig_i = beams(0, 3);
    step();
    trig_i = '0;
    step_n(3);
    check("idle_no_fire", 32'(m_trig_tvalid), 0);

    // Single fire at ts=3 with 2-cycle latency.
    holdoff_i = 16'd10;
    do_runrst();
    check("run_running", 32'(running_o), 1);
    step_n(3);
    exp_q.push_back(32'h0500_0003);
    trig_i = beams(5, 5);
    step();
    trig_i = '0;
    check("single_lat_k", 32'(m_trig_tvalid), 0);
    step();
    check("single_lat_k1", 32'(m_trig_tvalid), 1);
    check("single_tdata", m_trig_tdata, 32'h0500_0003);
    step();
    check("single_done", 32'(m_trig_tvalid), 0);
    check("single_q_empty", 32'(exp_q.size()), 0);

    // Vector table: simultaneous firings emerge on consecutive cycles in ascending order.
    holdoff_i = 16'd0;
    do_runrst();
    foreach (vecs[i]) begin
      beam_mask_i = vecs[i].mask;
      fire(vecs[i].trig, vecs[i].trig & vecs[i].mask);
      step_n(vecs[i].nwords);
      if (vecs[i].nwords > 0) check($sformatf("tbl%0d_last_valid", i), 32'(m_trig_tvalid), 1);
      step();
      check($sformatf("tbl%0d_valid_low", i), 32'(m_trig_tvalid), 0);
      check($sformatf("tbl%0d_drained", i), 32'(exp_q.size()), 0);
      step_n(2);
    end

    // Holdoff 4 on beam 2 held high; beam 3 masked.
    beam_mask_i = ~beams(3, 3);
    holdoff_i   = 16'd4;
    do_runrst();
    exp_q.push_back(32'h0200_0000);
    exp_q.push_back(32'h0200_0005);
    exp_q.push_back(32'h0200_000A);
    trig_i = beams(2, 3);
    step_n(13);
    trig_i = '0;
    step_n(4);
    check("hold_q_empty", 32'(exp_q.size()), 0);
    check("hold_drop", 32'(drop_count_o), 0);

    // Backpressure: 20 firings into a 16-deep FIFO, then drops on still-pending beams.
    beam_mask_i   = {NB{1'b1}};
    holdoff_i     = 16'd0;
    m_trig_tready = 1'b0;
    do_runrst();
    step_n(2);
    fire(beams(0, 19), beams(0, 19));
    step_n(20);
    head = exp_q[0];
    check("bp_valid", 32'(m_trig_tvalid), 1);
    check("bp_head", m_trig_tdata, head);
    for (int b = 16; b <= 19; b++) begin
      trig_i = beams(b, b);
      step();
    end
    trig_i = '0;
    step();
    check("bp_drop4", 32'(drop_count_o), 32'(exp_drop4));
    trig_i = beams(16, 19);
    step();
    trig_i = '0;
    step();
    check("bp_drop_per_cycle", 32'(drop_count_o), 32'(exp_drop5));
    check("bp_head_stable", m_trig_tdata, head);
    m_trig_tready = 1'b1;
    step_n(24);
    check("bp_q_empty", 32'(exp_q.size()), 0);
    check("bp_valid_low", 32'(m_trig_tvalid), 0);

    // Stop/drain with 3 queued words; firings during drain are ignored.
    m_trig_tready = 1'b0;
    do_runrst();
    fire(beams(1, 3), beams(1, 3));
    step_n(4);
    check("drain_running_before", 32'(running_o), 1);
    runstop_i = 1'b1;
    step();
    runstop_i = 1'b0;
    check("drain_running_after", 32'(running_o), 0);
    fire(beams(4, 4), '0);
    step_n(2);
    m_trig_tready = 1'b1;
    step_n(6);
    check("drain_q_empty", 32'(exp_q.size()), 0);
    check("drain_valid_low", 32'(m_trig_tvalid), 0);
    fire(beams(6, 6), '0);
    step_n(3);
    check("drain_idle_quiet", 32'(m_trig_tvalid), 0);

    // Restart mid-stream with runrst and runstop together: runrst wins, queued words lost.
    m_trig_tready = 1'b0;
    do_runrst();
    fire(beams(0, 2), beams(0, 2));
    step_n(4);
    check("rr_valid_before", 32'(m_trig_tvalid), 1);
    exp_q.delete();
    runrst_i  = 1'b1;
    runstop_i = 1'b1;
    step();
    runrst_i  = 1'b0;
    runstop_i = 1'b0;
    run_base  = cyc;
    check("rr_valid_after", 32'(m_trig_tvalid), 0);
    check("rr_tdata_after", m_trig_tdata, 0);
    check("rr_running", 32'(running_o), 1);
    m_trig_tready = 1'b1;
    step_n(2);
    exp_q.push_back(32'h0900_0002);
    trig_i = beams(9, 9);
    step();
    trig_i = '0;
    step_n(3);
    check("rr_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-burst.
    m_trig_tready = 1'b0;
    fire(beams(10, 12), beams(10, 12));
    step_n(4);
    check("arst_valid_before", 32'(m_trig_tvalid), 1);
    exp_q.delete();
    #2;
    ifclk_rstn_i = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_trig_tvalid), 0);
    check("arst_tdata", m_trig_tdata, 0);
    check("arst_running", 32'(running_o), 0);
    check("arst_drop", 32'(drop_count_o), 0);
    step();
    ifclk_rstn_i  = 1'b1;
    m_trig_tready = 1'b1;
    step_n(3);
    check("arst_idle", 32'(running_o), 0);
    check("final_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lf_trigger_generator.md
# lf_trigger_generator

Parametrised low-frequency trigger generator for the ifclk domain. It takes the per-beam trigger vector from the LF trigger core, applies a beam mask and per-beam holdoff, and timestamps each firing. It serialises simultaneous firings one beam per cycle into a small FIFO and streams them out as 32-bit AXI4-Stream-min words. It is the run-controlled back end that replaces the fixed-width generator stage behind the LF trigger wrapper.

## Interface
Parameters:
- NBEAMS, 48, number of beams; legal range 1..256.
- HOLDOFF_BITS, 16, width of the holdoff counters.
- FIFO_DEPTH, 16, output FIFO depth; power of two, ≥ 4.

Ports:
- ifclk  in  1  sole clock.
- ifclk_rstn_i  in  1  asynchronous, active-low reset.
- runrst_i  in  1  single-cycle pulse; starts or restarts a run.
- runstop_i  in  1  single-cycle pulse; ends the run.
- trig_i  in  NBEAMS  raw beam triggers, level per cycle.
- beam_mask_i  in  NBEAMS  1 = beam enabled; quasi-static.
- holdoff_i  in  HOLDOFF_BITS  holdoff length in cycles; quasi-static.
- m_trig_tdata  out  32  bits [31:24] = beam index, bits [23:0] = timestamp.
- m_trig_tvalid  out  1  AXI4-S valid.
- m_trig_tready  in  1  AXI4-S ready.
- running_o  out  1  high while in state RUN.
- drop_count_o  out  16  number of dropped firings, saturating.

## Operation
- FSM has three states. Reset state is IDLE.
  - IDLE: on runrst_i, go to RUN.
  - RUN: on runstop_i, go to DRAIN.
  - DRAIN: when pending == 0 and the FIFO is empty, go to IDLE.
  - runrst_i in any state performs a flush and goes to RUN.
- Flush clears the timestamp counter, all pending bits, all holdoff counters and the FIFO. drop_count_o is also cleared.
- Timestamp ts:
  - 24-bit, counts +1 per cycle in RUN and DRAIN, holds in IDLE.
  - Wraps 0xFFFFFF → 0 with no flag.
- Firing rule, per beam b: fire[b] = state==RUN & trig_i[b] & beam_mask_i[b] & (hold[b]==0) & ~pending[b].
- On fire[b]:
  - pending[b] ← 1 and stamp[b] ← ts.
  - hold[b] ← holdoff_i; hold[b] decrements to 0 each cycle after.
  - holdoff_i = 0 re-arms the beam on the next cycle.
- Drop: trig_i[b] & beam_mask_i[b] & state==RUN & hold[b]==0 & pending[b] increments drop_count_o.
  - At most +1 per cycle regardless of how many beams drop.
- Scanner: each cycle, if pending ≠ 0 and the FIFO is not full, it selects the lowest-index pending beam. It writes {b[7:0], stamp[b]} to the FIFO and clears pending[b].
- Set and clear of the same pending bit cannot coincide, because fire requires ~pending.
- FIFO full: the scanner stalls and pending bits hold. Further firings on already-pending beams count as drops.
- Masking a beam does not cancel its pending entry.
- Output is first-word-fall-through. A word transfers on tvalid & tready. tdata is stable while tvalid & ~tready.

## Timing
- Reset values:
  - m_trig_tvalid = 0, m_trig_tdata = 0, running_o = 0, drop_count_o = 0.
  - State IDLE; all pending, hold and stamp registers = 0.
- A fire sampled at edge k sets pending at k. The scanner writes the FIFO at edge k+1. m_trig_tvalid is high after edge k+1, giving 2-cycle latency with an empty FIFO.
- N simultaneous firings emit over N consecutive cycles in ascending beam order (with tready held high).
- runrst_i and runstop_i in the same cycle: runrst_i wins.
- runrst_i asserted mid-stream drops m_trig_tvalid on the next cycle. Words not yet transferred are lost.
- running_o falls one cycle after runstop_i.

## Configuration
- LF_TRIG_DROPCOUNT_EN defined: drop detection and the saturating 16-bit counter are built.
- LF_TRIG_DROPCOUNT_EN undefined: drop_count_o is tied to 0 and no drop logic is built. All other behaviour is identical.

## Structure
- Package lf_trigger_pkg holds:
  - TS_BITS = 24.
  - Field constants BEAM_LSB = 24 and TS_MSB = 23.
  - State enum {IDLE, RUN, DRAIN}.
- One sub-module, lf_trig_fifo: synchronous FWFT FIFO of width 32 and depth FIFO_DEPTH, with flush input and full/empty outputs.
- The priority encoder and holdoff counters are generate loops in the top module.

## Test plan
- Single fire: runrst, holdoff 10, pulse trig_i[5] at ts=3 → one word 0x05000003, tvalid 2 cycles after the sampled edge.
- Simultaneous beams: trig_i bits 0, 7 and 47 together at ts=T, tready=1 → words 0x00/0x07/0x2F with timestamp T on 3 consecutive cycles.
- Holdoff: holdoff 4, trig_i[2] held high → fires at ts 0, 5, 10, … Beam 3 masked with trig high → no words.
- Backpressure: tready=0, fire 20 beams into depth 16 → 16 words buffered, 4 remain pending. Re-trigger those 4 → drop_count_o=4 (0 with the macro off). Release tready → 20 words, ascending order.
- Stop/drain: runstop_i with 3 words queued → running_o low next cycle, no new words accepted, 3 words drain, state returns to IDLE.
- Reset mid-run: runrst_i while FIFO non-empty → tvalid 0 next cycle, ts restarts at 0. Async ifclk_rstn_i low mid-burst → all outputs at reset values immediately.
